// File: rtl/mem_port_arbiter.sv
// Round-robin two-port arbiter/sequencer for the shared-bus data memory (two-phase write, combinational read).
// Optional write-verify read-back enabled by defining MEM_ARB_WRITE_VERIFY_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp_err,
    output logic                  mem_write_req,
    output logic [ADDR_WIDTH-1:0] mem_req_bus,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_DATA,
        S_WR_ADDR,
        S_VERIFY,
        S_RSP
    } state_t;

    state_t                  state_q;
    logic                    port_q;
    logic                    prio_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   bus_q;
    logic                    rsp0_valid_q;
    logic                    rsp1_valid_q;
    logic [DATA_WIDTH-1:0]   rsp0_rdata_q;
    logic [DATA_WIDTH-1:0]   rsp1_rdata_q;
`ifdef MEM_ARB_WRITE_VERIFY_EN
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    rsp_err_q;
`endif

    logic                    can_grant;
    logic                    grant0;
    logic                    grant1;
    logic                    gnt_we;
    logic [ADDR_WIDTH-1:0]   gnt_addr;
    logic [DATA_WIDTH-1:0]   gnt_wdata;
    logic                    rsp_fire;
    logic [DATA_WIDTH-1:0]   rsp_data;

    // The RSP cycle doubles as an idle cycle so reads can issue every two cycles.
    always_comb begin
        can_grant = (state_q == S_IDLE) || (state_q == S_RSP);
        grant1    = can_grant && req1_valid && (!req0_valid || prio_q);
        grant0    = can_grant && req0_valid && !grant1;
        gnt_we    = grant1 ? req1_we    : req0_we;
        gnt_addr  = grant1 ? req1_addr  : req0_addr;
        gnt_wdata = grant1 ? req1_wdata : req0_wdata;
    end

    always_comb begin
        rsp_fire = 1'b0;
        rsp_data = '0;
        case (state_q)
            S_RD: begin
                rsp_fire = 1'b1;
                rsp_data = mem_rdata;
            end
`ifdef MEM_ARB_WRITE_VERIFY_EN
            S_VERIFY:  rsp_fire = 1'b1;
`else
            S_WR_ADDR: rsp_fire = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            port_q       <= 1'b0;
            prio_q       <= 1'b0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            bus_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
`ifdef MEM_ARB_WRITE_VERIFY_EN
            wdata_q      <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            wr_q         <= 1'b0;
            bus_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
`ifdef MEM_ARB_WRITE_VERIFY_EN
            rsp_err_q    <= 1'b0;
`endif
            case (state_q)
                S_IDLE, S_RSP: begin
                    if (grant0 || grant1) begin
                        port_q <= grant1;
                        prio_q <= grant0;
                        addr_q <= gnt_addr;
`ifdef MEM_ARB_WRITE_VERIFY_EN
                        wdata_q <= gnt_wdata;
`endif
                        if (gnt_we) begin
                            state_q <= S_WR_DATA;
                            wr_q    <= 1'b1;
                            bus_q   <= ADDR_WIDTH'(gnt_wdata);
                        end else begin
                            state_q <= S_RD;
                            bus_q   <= gnt_addr;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RD: state_q <= S_RSP;
                S_WR_DATA: begin
                    state_q <= S_WR_ADDR;
                    bus_q   <= addr_q;
                end
`ifdef MEM_ARB_WRITE_VERIFY_EN
                S_WR_ADDR: begin
                    state_q <= S_VERIFY;
                    bus_q   <= addr_q;
                end
                S_VERIFY: begin
                    state_q   <= S_RSP;
                    rsp_err_q <= (mem_rdata != wdata_q);
                end
`else
                S_WR_ADDR: state_q <= S_RSP;
                S_VERIFY:  state_q <= S_IDLE;
`endif
                default: state_q <= S_IDLE;
            endcase

            if (rsp_fire) begin
                if (port_q) begin
                    rsp1_valid_q <= 1'b1;
                    rsp1_rdata_q <= rsp_data;
                end else begin
                    rsp0_valid_q <= 1'b1;
                    rsp0_rdata_q <= rsp_data;
                end
            end
        end
    end

    assign req0_ready    = grant0;
    assign req1_ready    = grant1;
    assign rsp0_valid    = rsp0_valid_q;
    assign rsp1_valid    = rsp1_valid_q;
    assign rsp0_rdata    = rsp0_rdata_q;
    assign rsp1_rdata    = rsp1_rdata_q;
    assign mem_write_req = wr_q;
    assign mem_req_bus   = bus_q;
`ifdef MEM_ARB_WRITE_VERIFY_EN
    assign rsp_err       = rsp_err_q;
`else
    assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: behavioural two-phase memory, dictionary reference memory,
// latency/arbitration rules computed per accepted request; honours MEM_ARB_WRITE_VERIFY_EN.
module tb_mem_port_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;
`ifdef MEM_ARB_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req0_we = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req0_ready, rsp0_valid, req1_ready, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          rsp_err, mem_write_req;
    logic [AW-1:0] mem_req_bus;
    logic [DW-1:0] mem_rdata;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .rsp_err(rsp_err), .mem_write_req(mem_write_req), .mem_req_bus(mem_req_bus),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Two-phase memory: data latched while write_req=1, committed next cycle at the bus address.
    logic [7:0] mem [0:32767];
    logic       ph;
    logic [7:0] ph_data;
    bit         corrupt = 1'b0;
    initial for (int i = 0; i < 32768; i++) mem[i] <= 8'h00;
    always @(posedge clk or posedge reset) begin
        if (reset) ph <= 1'b0;
        else if (mem_write_req) begin
            ph      <= 1'b1;
            ph_data <= mem_req_bus[7:0];
        end else if (ph) begin
            mem[mem_req_bus] <= ph_data ^ {7'b0, corrupt};
            ph <= 1'b0;
        end
    end
    assign mem_rdata = mem[mem_req_bus];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model
    typedef struct {int port; logic [7:0] rdata; logic err; int due;} exp_t;
    exp_t          sbq[$];
    logic [7:0]    ref_mem [int];
    logic [AW-1:0] exp_bus [int];
    bit            exp_wr [int];
    int            busy_until = 0;
    int            last_grant = 1;
    bit            acc [2];
    int            acc_cyc [2];
    int            grant_log[$];
    int            last_wr_addr;
    logic [7:0]    last_wr_old;

    function automatic logic [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic accept(input int p, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        exp_t e;
        int a = int'(addr);
        last_grant = p;
        acc[p] = 1'b1;
        acc_cyc[p] = cyc;
        grant_log.push_back(p);
        e.port = p; e.err = 1'b0; e.rdata = 8'h00;
        if (we) begin
            last_wr_addr = a;
            last_wr_old  = ref_rd(a);
            ref_mem[a]   = wd ^ {7'b0, corrupt};
            exp_wr[cyc+1]  = 1'b1;
            exp_bus[cyc+1] = AW'(wd);
            exp_bus[cyc+2] = addr;
            if (VERIFY) begin
                exp_bus[cyc+3] = addr;
                e.err = corrupt;
                e.due = cyc + 4;
            end else e.due = cyc + 3;
        end else begin
            e.rdata = ref_rd(a);
            exp_bus[cyc+1] = addr;
            e.due = cyc + 2;
        end
        busy_until = e.due;
        sbq.push_back(e);
    endtask

    // Request side: expected ready from round-robin rules, push expectation on handshake.
    always @(negedge clk) begin : req_monitor
        bit free, e0, e1;
        if (reset) begin
            busy_until = 0;
            last_grant = 1;
        end else begin
            free = (cyc >= busy_until);
            e0 = free && req0_valid && (!req1_valid || last_grant == 1);
            e1 = free && req1_valid && (!req0_valid || last_grant == 0);
            chk("req0_ready", 32'(req0_ready), 32'(e0));
            chk("req1_ready", 32'(req1_ready), 32'(e1));
            chk("ready_both", 32'(req0_ready && req1_ready), 0);
            if (req0_valid && req0_ready) accept(0, req0_we, req0_addr, req0_wdata);
            else if (req1_valid && req1_ready) accept(1, req1_we, req1_addr, req1_wdata);
        end
    end

    // Response side: bus protocol per cycle and scoreboard pops.
    bit prev_wr = 1'b0;
    always @(negedge clk) begin : rsp_monitor
        logic [AW-1:0] eb;
        bit ew;
        exp_t e;
        if (!reset) begin
            eb = exp_bus.exists(cyc) ? exp_bus[cyc] : '0;
            ew = exp_wr.exists(cyc) ? exp_wr[cyc] : 1'b0;
            chk("mem_req_bus", 32'(mem_req_bus), 32'(eb));
            chk("mem_write_req", 32'(mem_write_req), 32'(ew));
            chk("wr_req_consecutive", 32'(mem_write_req && prev_wr), 0);
            prev_wr = mem_write_req;
            if (rsp0_valid || rsp1_valid) begin
                chk("rsp_both", 32'(rsp0_valid && rsp1_valid), 0);
                chk("rsp_expected", 32'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("rsp_port", 32'(rsp1_valid), 32'(e.port));
                    chk("rsp_latency", cyc, e.due);
                    chk("rsp_rdata", 32'(e.port == 1 ? rsp1_rdata : rsp0_rdata), 32'(e.rdata));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
                chk("rsp_missing", 32'(rsp0_valid || rsp1_valid), 1);
                void'(sbq.pop_front());
            end
        end else prev_wr = 1'b0;
        exp_bus.delete(cyc);
        exp_wr.delete(cyc);
    end

    // Stimulus
    logic          v [2] = '{1'b0, 1'b0};
    logic          we_a [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd_a [2];

    task automatic drive();
        req0_valid = v[0]; req0_we = we_a[0]; req0_addr = ad[0]; req0_wdata = wd_a[0];
        req1_valid = v[1]; req1_we = we_a[1]; req1_addr = ad[1]; req1_wdata = wd_a[1];
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit done = 1'b0;
        v[p] = 1'b1; we_a[p] = we; ad[p] = a; wd_a[p] = d;
        drive();
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            if (acc[p]) begin
                acc[p] = 1'b0;
                done = 1'b1;
            end
        end
        chk("issue_accepted", 32'(done), 1);
        v[p] = 1'b0;
        drive();
    endtask

    task automatic rand_req(input int p, input bit allow_write);
        logic [AW-1:0] a;
        case ($urandom_range(0, 5))
            0:       a = '0;
            1:       a = 15'h7FFF;
            5:       a = AW'($urandom);
            default: a = AW'($urandom_range(0, 7));
        endcase
        v[p] = 1'b1;
        we_a[p] = allow_write ? 1'($urandom_range(0, 1)) : 1'b0;
        ad[p] = a;
        wd_a[p] = DW'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (v[0] || v[1]); k++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) if (acc[p]) begin acc[p] = 1'b0; v[p] = 1'b0; end
            drive();
        end
        chk("drain_done", 32'(v[0] || v[1]), 0);
        v[0] = 1'b0; v[1] = 1'b0;
        drive();
    endtask

    initial begin
        int t;
        we_a = '{1'b0, 1'b0}; ad = '{'0, '0}; wd_a = '{'0, '0};
        @(posedge clk); #1;
        chk("reset_wr_req", 32'(mem_write_req), 0);
        chk("reset_bus", 32'(mem_req_bus), 0);
        chk("reset_rsp0_valid", 32'(rsp0_valid), 0);
        chk("reset_rsp1_valid", 32'(rsp1_valid), 0);
        chk("reset_rsp0_rdata", 32'(rsp0_rdata), 0);
        chk("reset_rsp1_rdata", 32'(rsp1_rdata), 0);
        chk("reset_rsp_err", 32'(rsp_err), 0);
        idle(2);
        reset = 1'b0;
        idle(2);

        // Write then read back on port 0
        issue(0, 1'b1, 15'h0012, 8'hA5);
        idle(4);
        issue(0, 1'b0, 15'h0012, 8'h00);
        idle(3);

        // Top/bottom addresses, back-to-back reads on port 1
        issue(1, 1'b1, 15'h7FFF, 8'h77);
        idle(4);
        issue(1, 1'b1, 15'h0000, 8'h11);
        idle(4);
        issue(1, 1'b0, 15'h7FFF, 8'h00);
        t = acc_cyc[1];
        issue(1, 1'b0, 15'h0000, 8'h00);
        chk("b2b_spacing", acc_cyc[1] - t, 2);
        idle(3);

        // Both ports requesting continuously: grants must alternate starting at port 0
        grant_log.delete();
        rand_req(0, 1'b0);
        rand_req(1, 1'b0);
        drive();
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) if (acc[p]) begin acc[p] = 1'b0; rand_req(p, 1'b0); end
            drive();
        end
        drain();
        chk("grant_count", 32'(grant_log.size() >= 8), 1);
        if (grant_log.size() > 0) chk("grant_first", grant_log[0], 0);
        for (int i = 1; i < grant_log.size(); i++)
            chk("grant_alternate", grant_log[i], 1 - grant_log[i-1]);
        idle(4);

        // Reset during the data phase of a write: no response, no commit
        issue(0, 1'b1, 15'h0100, 8'h3C);
        idle(5);
        v[0] = 1'b1; we_a[0] = 1'b1; ad[0] = 15'h0100; wd_a[0] = 8'hC3;
        drive();
        for (int k = 0; k < 20 && !acc[0]; k++) begin @(posedge clk); #1; end
        chk("rst_write_accepted", 32'(acc[0]), 1);
        acc[0] = 1'b0; v[0] = 1'b0;
        drive();
        chk("rst_in_wr_data", 32'(mem_write_req), 1);
        #2;
        reset = 1'b1;
        sbq.delete();
        exp_bus.delete();
        exp_wr.delete();
        ref_mem[last_wr_addr] = last_wr_old;
        #1;
        chk("rst_mid_wr_req", 32'(mem_write_req), 0);
        chk("rst_mid_bus", 32'(mem_req_bus), 0);
        chk("rst_mid_rsp0", 32'(rsp0_valid), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        issue(0, 1'b0, 15'h0100, 8'h00);
        idle(3);

        // Memory corrupts bit 0 on commit
        corrupt = 1'b1;
        issue(1, 1'b1, 15'h0055, 8'h5A);
        idle(5);
        corrupt = 1'b0;
        issue(1, 1'b0, 15'h0055, 8'h00);
        idle(3);

        // Random mixed traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin acc[p] = 1'b0; v[p] = 1'b0; end
                if (!v[p] && $urandom_range(0, 99) < 40) rand_req(p, 1'b1);
            end
            drive();
        end
        drain();
        idle(8);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
